// File: rtl/pca9685_pkg.sv
// Register map constants and blob helpers shared by the PCA9685-style blocks.
// Byte n of the flat register blob occupies bits [n*8 : n*8+7], MSB first.
package pca9685_pkg;

    localparam int MODE1_ADDR     = 'h00;
    localparam int MODE2_ADDR     = 'h01;
    localparam int LED0_ON_L_ADDR = 'h06;
    localparam int PRESCALE_ADDR  = 'hFE;
    localparam int LED_STRIDE     = 4;

    localparam int SLEEP_BIT = 4;
    localparam int INVRT_BIT = 4;
    localparam int FULL_BIT  = 4;

    function automatic logic [7:0] blob_byte(input logic [0:2047] blob, input int idx);
        return blob[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/pca_pwm_channel.sv
// One PWM channel: period-boundary shadow registers, priority compare and the
// registered output bit.
module pca_pwm_channel
    import pca9685_pkg::*;
#(
    parameter int CNT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 sleep,
    input  logic                 invert,
    input  logic [CNT_WIDTH-1:0] cnt,
    input  logic [7:0]           on_l,
    input  logic [7:0]           on_h,
    input  logic [7:0]           off_l,
    input  logic [7:0]           off_h,
    output logic                 pwm
);

    logic [CNT_WIDTH-1:0] on_q;
    logic [CNT_WIDTH-1:0] off_q;
    logic                 full_on_q;
    logic                 full_off_q;
    logic                 level;
    logic                 unused_hi;

    assign unused_hi = ^{on_h[7:5], off_h[7:5]};

    // full_off beats full_on; on>off describes a window that wraps through 0.
    always_comb begin
        level = 1'b0;
        if (full_off_q) begin
            level = 1'b0;
        end else if (full_on_q) begin
            level = 1'b1;
        end else if (on_q == off_q) begin
            level = 1'b0;
        end else if (on_q < off_q) begin
            level = (cnt >= on_q) && (cnt < off_q);
        end else begin
            level = (cnt >= on_q) || (cnt < off_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_q       <= '0;
            off_q      <= '0;
            full_on_q  <= 1'b0;
            full_off_q <= 1'b0;
            pwm        <= 1'b0;
        end else begin
            if (load) begin
                on_q       <= {on_h[3:0], on_l};
                off_q      <= {off_h[3:0], off_l};
                full_on_q  <= on_h[FULL_BIT];
                full_off_q <= off_h[FULL_BIT];
            end
            pwm <= (sleep ? 1'b0 : level) ^ invert;
        end
    end

endmodule

// File: rtl/pca_pwm_engine.sv
// Prescaled 12-bit PWM engine driven from the shared register blob.
// Optional output inversion from MODE2.INVRT is built when PCA_PWM_INVRT_EN is defined.
module pca_pwm_engine
    import pca9685_pkg::*;
#(
    parameter int NUM_CHANNELS = 16,
    parameter int CNT_WIDTH    = 12,
    parameter int PRESCALE_MIN = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [0:2047]           register_blob_i,
    output logic [NUM_CHANNELS-1:0] pwm_o,
    output logic                    period_start_o,
    output logic [CNT_WIDTH-1:0]    count_o
);

    logic [7:0]           mode1;
    logic [7:0]           prescale;
    logic [7:0]           eff_pre;
    logic [7:0]           eff_pre_q;
    logic [7:0]           pre_cnt_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 period_start_q;
    logic                 sleep;
    logic                 invert;
    logic                 tick;
    logic                 wrap_tick;
    logic                 load;
    logic                 unused_bits;

    assign mode1       = blob_byte(register_blob_i, MODE1_ADDR);
    assign prescale    = blob_byte(register_blob_i, PRESCALE_ADDR);
    assign sleep       = mode1[SLEEP_BIT];
    assign unused_bits = ^{register_blob_i, mode1};

`ifdef PCA_PWM_INVRT_EN
    logic [7:0] mode2;
    logic       unused_mode2;
    assign mode2        = blob_byte(register_blob_i, MODE2_ADDR);
    assign invert       = mode2[INVRT_BIT];
    assign unused_mode2 = ^mode2;
`else
    assign invert = 1'b0;
`endif

    assign eff_pre   = (prescale < 8'(PRESCALE_MIN)) ? 8'(PRESCALE_MIN) : prescale;
    assign tick      = (pre_cnt_q == eff_pre_q);
    assign wrap_tick = tick && (count_q == {CNT_WIDTH{1'b1}});
    // Shadows track the blob continuously while asleep, otherwise only at the wrap.
    assign load      = sleep || wrap_tick;

    // eff_pre_q holds the divide value for the interval in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_cnt_q      <= '0;
            eff_pre_q      <= 8'(PRESCALE_MIN);
            count_q        <= '0;
            period_start_q <= 1'b0;
        end else if (sleep) begin
            pre_cnt_q      <= '0;
            eff_pre_q      <= eff_pre;
            count_q        <= '0;
            period_start_q <= 1'b0;
        end else if (tick) begin
            pre_cnt_q      <= '0;
            eff_pre_q      <= eff_pre;
            count_q        <= count_q + 1'b1;
            period_start_q <= wrap_tick;
        end else begin
            pre_cnt_q      <= pre_cnt_q + 1'b1;
            period_start_q <= 1'b0;
        end
    end

    assign count_o        = count_q;
    assign period_start_o = period_start_q;

    for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_ch
        localparam int BASE = LED0_ON_L_ADDR + LED_STRIDE * n;
        pca_pwm_channel #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_ch (
            .clk    (clk_i),
            .rst_n  (rst_ni),
            .load   (load),
            .sleep  (sleep),
            .invert (invert),
            .cnt    (count_q),
            .on_l   (blob_byte(register_blob_i, BASE)),
            .on_h   (blob_byte(register_blob_i, BASE + 1)),
            .off_l  (blob_byte(register_blob_i, BASE + 2)),
            .off_h  (blob_byte(register_blob_i, BASE + 3)),
            .pwm    (pwm_o[n])
        );
    end

endmodule
